// File: rtl/cpu_mem_bridge_pkg.sv
// Shared constants for cpu_mem_bridge: one-hot FSM encoding and transaction source tags.
package cpu_mem_bridge_pkg;

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_REQ  = 4'b0010;
    localparam logic [3:0] S_RESP = 4'b0100;
    localparam logic [3:0] S_RET  = 4'b1000;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // Read completion goes back to whichever channel issued it.
    function automatic logic ret_ready(input logic src, input logic inst_rdy, input logic data_rdy);
        return (src == SRC_DATA) ? data_rdy : inst_rdy;
    endfunction

endpackage

// File: rtl/cpu_mem_bridge_perf_sat_cnt.sv
// perf_sat_cnt: saturating event counter with synchronous clear, used by the optional perf block.
module perf_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: merges CPU fetch and load/store channels onto one memory port, one transaction at a time.
// Optional performance counters are enabled with `define CPU_MEM_BRIDGE_PERF_EN.
module cpu_mem_bridge
    import cpu_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   inst_req_addr,
    input  logic                inst_req_valid,
    output logic                inst_req_ready,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_valid,
    input  logic                inst_ready,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                data_rd,
    input  logic                data_wr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_req_ready,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_rvalid,
    input  logic                data_rready,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                mem_resp_ready
`ifdef CPU_MEM_BRIDGE_PERF_EN
    ,
    output logic [31:0]         perf_wait_cyc,
    output logic [31:0]         perf_conflict,
    output logic [31:0]         perf_writes
`endif
);

    localparam int STRB_W = DATA_W / 8;

    logic [3:0]        state_r;
    logic [3:0]        state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic              wen_r;
    logic [DATA_W-1:0] wdata_r;
    logic [STRB_W-1:0] wstrb_r;
    logic              src_r;
    logic [DATA_W-1:0] rdata_r;

    logic idle_s;
    logic ret_s;
    logic data_req_s;
    logic accept_data_s;
    logic accept_inst_s;

    // Arbitration: a pending load/store always beats a fetch.
    always_comb begin
        idle_s        = (state_r == S_IDLE);
        ret_s         = (state_r == S_RET);
        data_req_s    = data_rd | data_wr;
        accept_data_s = idle_s & data_req_s;
        accept_inst_s = idle_s & ~data_req_s & inst_req_valid;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_data_s || accept_inst_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = wen_r ? S_IDLE : S_RESP;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_RESP: begin
                if (mem_resp_valid) begin
                    state_nxt_s = S_RET;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            S_RET: begin
                if (ret_ready(src_r, inst_ready, data_rready)) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RET;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request payload latched at accept; rd+wr together is a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= {ADDR_W{1'b0}};
            wen_r   <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            wstrb_r <= {STRB_W{1'b0}};
            src_r   <= SRC_INST;
        end else if (accept_data_s) begin
            addr_r  <= data_addr;
            wen_r   <= data_wr;
            wdata_r <= data_wdata;
            wstrb_r <= data_wstrb;
            src_r   <= SRC_DATA;
        end else if (accept_inst_s) begin
            addr_r  <= inst_req_addr;
            wen_r   <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            wstrb_r <= {STRB_W{1'b0}};
            src_r   <= SRC_INST;
        end
    end

    // Read data capture; responses seen in IDLE are drained without capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == S_RESP) && mem_resp_valid) begin
            rdata_r <= mem_resp_data;
        end
    end

    assign inst_req_ready = accept_inst_s;
    assign data_req_ready = accept_data_s;
    assign mem_req_valid  = (state_r == S_REQ);
    assign mem_req_addr   = addr_r;
    assign mem_req_wen    = wen_r;
    assign mem_req_wdata  = wdata_r;
    assign mem_req_wstrb  = wstrb_r;
    assign mem_resp_ready = idle_s | (state_r == S_RESP);
    assign inst_valid     = ret_s & (src_r == SRC_INST);
    assign data_rvalid    = ret_s & (src_r == SRC_DATA);
    assign inst_rdata     = (ret_s && (src_r == SRC_INST)) ? rdata_r : {DATA_W{1'b0}};
    assign data_rdata     = (ret_s && (src_r == SRC_DATA)) ? rdata_r : {DATA_W{1'b0}};

`ifdef CPU_MEM_BRIDGE_PERF_EN
    logic wait_inc_s;
    logic conflict_inc_s;
    logic write_inc_s;

    assign wait_inc_s     = (state_r == S_REQ) | (state_r == S_RESP);
    assign conflict_inc_s = idle_s & inst_req_valid & data_req_s;
    assign write_inc_s    = accept_data_s & data_wr;

    perf_sat_cnt #(.W(32)) u_wait_cnt (
        .clk(clk), .rst(rst), .inc(wait_inc_s), .clr(1'b0), .count(perf_wait_cyc)
    );
    perf_sat_cnt #(.W(32)) u_conflict_cnt (
        .clk(clk), .rst(rst), .inc(conflict_inc_s), .clr(1'b0), .count(perf_conflict)
    );
    perf_sat_cnt #(.W(32)) u_write_cnt (
        .clk(clk), .rst(rst), .inc(write_inc_s), .clr(1'b0), .count(perf_writes)
    );
`endif

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed scenarios plus random traffic against a word-memory model.
module tb_cpu_mem_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] inst_req_addr;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] data_addr;
    logic        data_rd;
    logic        data_wr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_req_ready;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        data_rready;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_ready;
`ifdef CPU_MEM_BRIDGE_PERF_EN
    logic [31:0] perf_wait_cyc;
    logic [31:0] perf_conflict;
    logic [31:0] perf_writes;
`endif

    int errors = 0;
    int checks = 0;
    int exp_wait = 0;
    int exp_conflict = 0;
    int exp_writes = 0;

    logic [31:0] mem [logic [31:0]];

    cpu_mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req_addr(inst_req_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_rdata(inst_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .data_addr(data_addr), .data_rd(data_rd), .data_wr(data_wr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_req_ready(data_req_ready), .data_rdata(data_rdata),
        .data_rvalid(data_rvalid), .data_rready(data_rready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready)
`ifdef CPU_MEM_BRIDGE_PERF_EN
        ,
        .perf_wait_cyc(perf_wait_cyc), .perf_conflict(perf_conflict), .perf_writes(perf_writes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // One complete transaction: rw/pw/tw are wait cycles on mem_req_ready, the response, and CPU ready.
    // pend keeps a fetch request asserted that must not be accepted while the bridge is busy.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input int rw, input int pw, input int tw, input logic pend);
        logic        is_data;
        logic [31:0] exp_rd;
        is_data = rd | wr;
        exp_rd  = mem_read(addr);
        if (is_data) begin
            data_addr = addr; data_rd = rd; data_wr = wr; data_wdata = wd; data_wstrb = st;
            inst_req_valid = pend; inst_req_addr = $urandom;
        end else begin
            inst_req_addr = addr; inst_req_valid = 1'b1;
            data_addr = $urandom; data_rd = 1'b0; data_wr = 1'b0;
        end
        #1;
        chk("accept_data_ready", data_req_ready, is_data);
        chk("accept_inst_ready", inst_req_ready, !is_data);
        if (is_data && pend) exp_conflict++;
        if (wr) exp_writes++;
        tick();
        if (is_data) begin
            data_rd = 1'b0; data_wr = 1'b0; data_wdata = $urandom; data_wstrb = 4'($urandom);
        end else begin
            inst_req_valid = pend; inst_req_addr = $urandom;
        end
        data_addr = $urandom;
        for (int i = 0; i <= rw; i++) begin
            mem_req_ready = (i == rw);
            #1;
            chk("req_valid", mem_req_valid, 1'b1);
            chk("req_addr", mem_req_addr, addr);
            chk("req_wen", mem_req_wen, wr);
            if (wr) begin
                chk("req_wdata", mem_req_wdata, wd);
                chk("req_wstrb", mem_req_wstrb, st);
            end
            chk("req_no_resp", {inst_valid, data_rvalid}, 2'b00);
            chk("req_busy", inst_req_ready, 1'b0);
            exp_wait++;
            tick();
        end
        mem_req_ready = 1'b0;
        if (wr) begin
            mem[addr] = merge(mem_read(addr), wd, st);
            chk("wr_done_idle", {mem_req_valid, mem_resp_ready}, 2'b01);
            chk("wr_no_resp", {inst_valid, data_rvalid}, 2'b00);
        end else begin
            for (int i = 0; i <= pw; i++) begin
                mem_resp_valid = (i == pw);
                mem_resp_data  = (i == pw) ? exp_rd : $urandom;
                #1;
                chk("resp_ready", mem_resp_ready, 1'b1);
                chk("resp_req_low", mem_req_valid, 1'b0);
                chk("resp_no_early", {inst_valid, data_rvalid}, 2'b00);
                chk("resp_busy", inst_req_ready, 1'b0);
                exp_wait++;
                tick();
            end
            mem_resp_valid = 1'b0;
            for (int i = 0; i <= tw; i++) begin
                mem_resp_data = $urandom;
                if (is_data) begin
                    data_rready = (i == tw); inst_ready = 1'($urandom);
                end else begin
                    inst_ready = (i == tw); data_rready = 1'($urandom);
                end
                #1;
                chk("ret_inst_valid", inst_valid, !is_data);
                chk("ret_data_valid", data_rvalid, is_data);
                chk("ret_inst_rdata", inst_rdata, is_data ? 32'h0 : exp_rd);
                chk("ret_data_rdata", data_rdata, is_data ? exp_rd : 32'h0);
                chk("ret_busy", {inst_req_ready, mem_req_valid}, 2'b00);
                tick();
            end
            inst_ready = 1'b0; data_rready = 1'b0;
            #1;
            chk("ret_done", {inst_valid, data_rvalid, mem_req_valid}, 3'b000);
        end
        chk("idle_pending_inst", inst_req_ready, pend);
        inst_req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        inst_req_addr = 32'h0; inst_req_valid = 1'b0; inst_ready = 1'b0;
        data_addr = 32'h0; data_rd = 1'b0; data_wr = 1'b0; data_wdata = 32'h0; data_wstrb = 4'h0;
        data_rready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        tick(); tick();
        chk("rst_readies", {inst_req_ready, data_req_ready}, 2'b00);
        chk("rst_valids", {inst_valid, data_rvalid, mem_req_valid}, 3'b000);
        chk("rst_resp_ready", mem_resp_ready, 1'b1);
        chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
        chk("rst_payload", {mem_req_addr, mem_req_wen, mem_req_wstrb}, 37'h0);
        rst = 1'b0;
        exp_wait = 0; exp_conflict = 0; exp_writes = 0;
        // Stale response in IDLE is drained.
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
        #1;
        chk("drain_ready", mem_resp_ready, 1'b1);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("drain_no_valid", {inst_valid, data_rvalid, mem_req_valid}, 3'b000);

        mem[32'h100] = 32'h0000_0013;
        txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 1'b0);
        mem[32'h2000] = 32'hCAFE_F00D;
        txn(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 4, 2, 0, 1'b0);
        txn(1'b0, 1'b1, 32'h3004, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0, 1'b0);
        txn(1'b1, 1'b0, 32'h3004, 32'h0, 4'h0, 0, 0, 0, 1'b0);
        txn(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 0, 0, 1, 1'b1);
        txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 1, 0, 1'b0);
        txn(1'b1, 1'b1, 32'h2000, 32'h1111_2222, 4'b1100, 1, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 0, 0, 5, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 3);
            a   = (sel == 0) ? (32'h100 + 32'($urandom_range(0, 7)) * 32'd4)
                             : (32'h4000 + 32'($urandom_range(0, 7)) * 32'd4);
            txn(sel == 1 || sel == 3, sel >= 2, a, $urandom, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

`ifdef CPU_MEM_BRIDGE_PERF_EN
        chk("perf_wait_cyc", perf_wait_cyc, 32'(exp_wait));
        chk("perf_conflict", perf_conflict, 32'(exp_conflict));
        chk("perf_writes", perf_writes, 32'(exp_writes));
`endif

        // Reset while waiting for a read response.
        inst_req_addr = 32'h200; inst_req_valid = 1'b1;
        tick();
        inst_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("pre_rst_in_resp", {mem_req_valid, mem_resp_ready}, 2'b01);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", mem_req_valid, 1'b0);
        chk("rst_mid_valid", {inst_valid, data_rvalid}, 2'b00);
        tick();
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD_0BAD;
        #1;
        chk("post_rst_drain", mem_resp_ready, 1'b1);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("post_rst_no_valid", {inst_valid, data_rvalid, mem_req_valid}, 3'b000);
        tick();
        chk("post_rst_still_idle", {inst_valid, data_rvalid, mem_req_valid}, 3'b000);
        txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
